// File: rtl/vga_cmd_ctrl.sv
// vga_cmd_ctrl: keyboard-driven rectangle geometry/mode control, applied only during vblank.
// Define VGA_CMD_FIFO_EN for a 4-entry command FIFO; otherwise a single holding register.
module vga_cmd_ctrl #(
  parameter int STEP  = 5,
  parameter int H_MIN = 10,
  parameter int H_MAX = 190,
  parameter int W_MIN = 10,
  parameter int W_MAX = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       key_valid,
  input  logic [7:0] scancode,
  input  logic       vblank,
  output logic [8:0] half_h,
  output logic [9:0] half_w,
  output logic       flash,
  output logic       invert,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] fifo_level
);
`ifdef VGA_CMD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  typedef enum logic [1:0] {IDLE, WAIT_VB, APPLY} state_t;
  state_t r_state, w_state_nxt;
  logic       r_vb_d, r_flash, r_inv, r_ovf, w_flash_nxt, w_inv_nxt;
  logic       w_push, w_pop, w_push_ok, w_rise, w_full;
  logic [2:0] r_cnt, w_cnt_nxt, w_widx, w_op;
  logic [2:0] r_mem [DEPTH];
  logic [2:0] w_mem_nxt [DEPTH];
  logic [8:0] r_h, w_h_nxt;
  logic [9:0] r_w, w_w_nxt;
  always_comb begin
    w_op = 3'd7;
    case (scancode)
      8'h75:   w_op = 3'd0;
      8'h72:   w_op = 3'd1;
      8'h6B:   w_op = 3'd2;
      8'h74:   w_op = 3'd3;
      8'h2B:   w_op = 3'd4;
      8'h2D:   w_op = 3'd5;
      8'h2C:   w_op = 3'd6;
      default: w_op = 3'd7;
    endcase
  end
  assign w_push    = en & key_valid & (w_op != 3'd7);
  assign w_rise    = vblank & ~r_vb_d;
  assign w_pop     = en & (r_state == APPLY) & vblank & (r_cnt != 3'd0);
  assign w_full    = r_cnt == 3'(DEPTH);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_cnt_nxt = r_cnt + 3'(w_push_ok) - 3'(w_pop);
  assign w_widx    = r_cnt - 3'(w_pop);
  // Head-of-queue lives in slot 0; a pop shifts the rest down
  always_comb begin
    w_mem_nxt = r_mem;
    if (w_pop)
      for (int i = 0; i < DEPTH - 1; i++) w_mem_nxt[i] = r_mem[i+1];
    for (int i = 0; i < DEPTH; i++)
      if (w_push_ok && 3'(i) == w_widx) w_mem_nxt[i] = w_op;
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = (r_cnt != 3'd0) ? WAIT_VB : IDLE;
      WAIT_VB: w_state_nxt = w_rise ? APPLY : WAIT_VB;
      APPLY:   w_state_nxt = (w_cnt_nxt == 3'd0) ? IDLE : (!vblank ? WAIT_VB : APPLY);
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_h_nxt     = r_h;
    w_w_nxt     = r_w;
    w_flash_nxt = r_flash;
    w_inv_nxt   = r_inv;
    if (w_pop)
      case (r_mem[0])
        3'd0: w_h_nxt = (r_h >= 9'(H_MAX - STEP)) ? 9'(H_MAX) : r_h + 9'(STEP);
        3'd1: w_h_nxt = (r_h <= 9'(H_MIN + STEP)) ? 9'(H_MIN) : r_h - 9'(STEP);
        3'd2: w_w_nxt = (r_w >= 10'(W_MAX - STEP)) ? 10'(W_MAX) : r_w + 10'(STEP);
        3'd3: w_w_nxt = (r_w <= 10'(W_MIN + STEP)) ? 10'(W_MIN) : r_w - 10'(STEP);
        3'd4: w_flash_nxt = ~r_flash;
        3'd5: w_inv_nxt = ~r_inv;
        3'd6: begin
          w_h_nxt     = 9'd20;
          w_w_nxt     = 10'd20;
          w_flash_nxt = 1'b0;
          w_inv_nxt   = 1'b0;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_vb_d  <= 1'b0;
      r_cnt   <= 3'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      r_h     <= 9'd20;
      r_w     <= 10'd20;
      r_flash <= 1'b0;
      r_inv   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_vb_d  <= vblank;
      r_cnt   <= w_cnt_nxt;
      r_mem   <= w_mem_nxt;
      r_h     <= w_h_nxt;
      r_w     <= w_w_nxt;
      r_flash <= w_flash_nxt;
      r_inv   <= w_inv_nxt;
      r_ovf   <= r_ovf | (w_push & ~w_push_ok);
    end
  end
  assign half_h     = r_h;
  assign half_w     = r_w;
  assign flash      = r_flash;
  assign invert     = r_inv;
  assign busy       = r_state != IDLE;
  assign overflow   = r_ovf;
  assign fifo_level = r_cnt;
endmodule

// File: tb/tb_vga_cmd_ctrl.sv
// tb_vga_cmd_ctrl: scoreboard bench; a queue-based reference model predicts the packed outputs every cycle.
module tb_vga_cmd_ctrl;
  localparam int STEP = 5, H_MIN = 10, H_MAX = 190, W_MIN = 10, W_MAX = 300;
`ifdef VGA_CMD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [25:0] RST_VEC = {9'd20, 10'd20, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  logic       clock = 1'b0;
  logic       reset, en, key_valid, vblank;
  logic [7:0] scancode;
  logic [8:0] half_h;
  logic [9:0] half_w;
  logic       flash, invert, busy, overflow;
  logic [2:0] fifo_level;
  vga_cmd_ctrl #(.STEP(STEP), .H_MIN(H_MIN), .H_MAX(H_MAX), .W_MIN(W_MIN), .W_MAX(W_MAX)) dut (
    .clock(clock), .reset(reset), .en(en), .key_valid(key_valid), .scancode(scancode),
    .vblank(vblank), .half_h(half_h), .half_w(half_w), .flash(flash), .invert(invert),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );
  always #5 clock = ~clock;
  wire [25:0] dut_vec = {half_h, half_w, flash, invert, busy, overflow, fifo_level};
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  int m_q[$];
  int m_st, m_h, m_w;
  bit m_vbd, m_fl, m_inv, m_ovf;
  logic [25:0] exp_q[$];
  logic [7:0] seq[$];
  function automatic int opcode(input logic [7:0] sc);
    case (sc)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h2B: return 4;
      8'h2D: return 5;
      8'h2C: return 6;
      default: return -1;
    endcase
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_st = 0; m_h = 20; m_w = 20;
    m_vbd = 0; m_fl = 0; m_inv = 0; m_ovf = 0;
  endtask
  function automatic logic [25:0] model_vec();
    return {9'(m_h), 10'(m_w), m_fl, m_inv, m_st != 0, m_ovf, 3'(m_q.size())};
  endfunction
  task automatic model_step(input bit e, input bit kv, input logic [7:0] sc, input bit vb);
    int sz0, op, cmd;
    bit rise, pop;
    if (!e) return;
    sz0  = m_q.size();
    rise = vb && !m_vbd;
    pop  = (m_st == 2) && vb && sz0 > 0;
    op   = opcode(sc);
    if (pop) begin
      cmd = m_q.pop_front();
      case (cmd)
        0: m_h = (m_h + STEP > H_MAX) ? H_MAX : m_h + STEP;
        1: m_h = (m_h - STEP < H_MIN) ? H_MIN : m_h - STEP;
        2: m_w = (m_w + STEP > W_MAX) ? W_MAX : m_w + STEP;
        3: m_w = (m_w - STEP < W_MIN) ? W_MIN : m_w - STEP;
        4: m_fl = !m_fl;
        5: m_inv = !m_inv;
        default: begin m_h = 20; m_w = 20; m_fl = 0; m_inv = 0; end
      endcase
    end
    if (kv && op >= 0) begin
      if (sz0 < DEPTH || pop) m_q.push_back(op);
      else m_ovf = 1;
    end
    case (m_st)
      0: if (sz0 > 0) m_st = 1;
      1: if (rise) m_st = 2;
      default: if (m_q.size() == 0) m_st = 0; else if (!vb) m_st = 1;
    endcase
    m_vbd = vb;
  endtask
  task automatic cyc(input bit e, input bit kv, input logic [7:0] sc, input bit vb, input string tag);
    en = e; key_valid = kv; scancode = sc; vblank = vb;
    model_step(e, kv, sc, vb);
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1 check(tag, dut_vec, exp_q.pop_front());
    @(negedge clock);
  endtask
  task automatic idle(input int n, input bit vb, input string tag);
    repeat (n) cyc(1, 0, 8'h00, vb, tag);
  endtask
  task automatic frame(input string tag);
    idle(2, 0, tag);
    idle(DEPTH + 3, 1, tag);
    idle(1, 0, tag);
  endtask
  task automatic run_seq(input string tag);
    while (seq.size() > 0) begin
      for (int j = 0; j < DEPTH && seq.size() > 0; j++) cyc(1, 1, seq.pop_front(), 0, tag);
      frame(tag);
    end
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1 check(tag, dut_vec, RST_VEC);
    model_reset();
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; en = 1'b1; key_valid = 1'b0; scancode = 8'h00; vblank = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_vec", dut_vec, RST_VEC);
    reset = 1'b0;
    cyc(1, 1, 8'h75, 0, "r22_key");
    idle(2, 0, "r22_wait");
    idle(3, 1, "r22_vb");
    idle(1, 0, "r22_end");
    check("r22_half_h", half_h, 25);
    check("r22_half_w", half_w, 20);
    check("r22_busy", busy, 0);
    repeat (22) seq.push_back(8'h72);
    run_seq("r23_hdec");
    check("r23_h_floor", half_h, 10);
    cyc(1, 1, 8'h11, 0, "bad_code");
    check("bad_code_lvl", fifo_level, 0);
    repeat (60) seq.push_back(8'h6B);
    run_seq("r23_winc");
    check("r23_w_ceil", half_w, 300);
    seq = '{8'h2C, 8'h2B, 8'h2D, 8'h2C};
    run_seq("r25_modes");
    check("r25_end", {half_h, half_w, flash, invert}, {9'd20, 10'd20, 2'b00});
    do_reset("r24_rst");
    seq = '{8'h75, 8'h75, 8'h6B, 8'h2B, 8'h2D};
    while (seq.size() > 0) cyc(1, 1, seq.pop_front(), 0, "r24_fill");
    check("r24_level", fifo_level, DEPTH);
    check("r24_ovf", overflow, 1);
    frame("r24_apply");
    check("r24_result", {half_h, half_w, flash, invert},
          (DEPTH == 4) ? {9'd30, 10'd25, 2'b10} : {9'd25, 10'd20, 2'b00});
    do_reset("r26_rst");
    repeat (4) cyc(1, 1, 8'h75, 0, "r26_fill");
    idle(1, 0, "r26_wait");
    idle(3, 1, "r26_pops");
    idle(1, 0, "r26_fall");
    check("r26_busy", busy, (DEPTH == 4) ? 1 : 0);
    check("r26_level", fifo_level, (DEPTH == 4) ? 2 : 0);
    cyc(0, 1, 8'h72, 1, "frz_a");
    cyc(0, 1, 8'h6B, 0, "frz_b");
    cyc(0, 0, 8'h00, 1, "frz_c");
    check("frz_level", fifo_level, (DEPTH == 4) ? 2 : 0);
    idle(2, 0, "r26_gap");
    idle(4, 1, "r26_rest");
    idle(1, 0, "r26_end");
    check("r26_half_h", half_h, (DEPTH == 4) ? 40 : 25);
    do_reset("r27_rst");
    repeat (DEPTH) cyc(1, 1, 8'h75, 0, "r27_fill");
    idle(1, 0, "r27_wait");
    cyc(1, 0, 8'h00, 1, "r27_rise");
    cyc(1, 1, 8'h6B, 1, "r27_coinc");
    check("r27_no_ovf", overflow, 0);
    check("r27_level", fifo_level, DEPTH);
    cyc(1, 0, 8'h00, 1, "r27_pop");
    do_reset("r27_mid_apply");
    check("r27_after_rst", dut_vec, RST_VEC);
    idle(4, 1, "r27_drained");
    idle(1, 0, "r27_final");
    check("r27_final_vec", dut_vec, RST_VEC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_cmd_ctrl.md
VGA_CMD_CTRL -- requirements
Module: vga_cmd_ctrl

Interface
REQ-001 Parameter STEP, default 5: geometry increment/decrement per key command.
REQ-002 Parameter H_MIN, default 10: lower bound of half_h.
REQ-003 Parameter H_MAX, default 190: upper bound of half_h.
REQ-004 Parameter W_MIN, default 10: lower bound of half_w.
REQ-005 Parameter W_MAX, default 300: upper bound of half_w.
REQ-006 Ports SHALL be, in order:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- key_valid  in  1  one-cycle pulse: key release with valid scancode.
- scancode  in  8  released key code, sampled when key_valid=1.
- vblank  in  1  level, high during vertical blanking, synchronous to clock.
- half_h  out  9  rectangle half-height.
- half_w  out  10  rectangle half-width.
- flash  out  1  flash mode enable.
- invert  out  1  colour inversion enable.
- busy  out  1  high when FSM is not IDLE.
- overflow  out  1  sticky: a command was dropped.
- fifo_level  out  3  number of queued commands.

Function
REQ-007 Decode on key_valid=1 and en=1: 0x75 H_INC, 0x72 H_DEC, 0x6B W_INC, 0x74 W_DEC, 0x2B FLASH_TGL, 0x2D INV_TGL, 0x2C RESTORE; all other codes SHALL be ignored and not queued.
- H_INC: half_h <= min(half_h+STEP, H_MAX).
- H_DEC: half_h <= max(half_h-STEP, H_MIN); no unsigned wrap.
- W_INC and W_DEC: same rules with W_MIN/W_MAX.
- FLASH_TGL: flash <= ~flash.
- INV_TGL: invert <= ~invert.
- RESTORE: half_h=20, half_w=20, flash=0, invert=0.
REQ-008 Decoded commands SHALL be pushed into a 4-entry FIFO as a 3-bit opcode and popped in arrival order.
REQ-009 A push to a full FIFO SHALL be dropped and SHALL set overflow=1; overflow stays 1 until reset.
REQ-010 Push and pop in the same cycle SHALL both succeed and leave fifo_level unchanged, including when the FIFO is full.
REQ-011 vblank rising edge: vblank=1 this cycle, 0 the previous cycle, detected with one register.
REQ-012 FSM states and transitions:
- IDLE: stays while FIFO empty; goes to WAIT_VB when non-empty.
- WAIT_VB: goes to APPLY on a vblank rising edge.
- APPLY: pops one command per cycle while vblank=1 and FIFO non-empty.
- APPLY exit: to IDLE when the FIFO becomes empty; to WAIT_VB when vblank=0 with entries left.
REQ-013 A popped command's effect SHALL be visible on the outputs at the same clock edge as the pop.
REQ-014 Geometry and mode outputs SHALL change only in APPLY, so there are no mid-frame updates.
REQ-015 A command enqueued while vblank is already high and the FSM is in IDLE SHALL wait for the next vblank rising edge.
REQ-016 With en=0, FSM, FIFO, outputs and the edge register SHALL hold, and key_valid SHALL be ignored.
REQ-017 busy SHALL equal (state != IDLE); fifo_level SHALL be registered.

Reset
REQ-018 On reset: half_h=20, half_w=20, flash=0, invert=0, busy=0, overflow=0, fifo_level=0, FSM=IDLE, FIFO emptied, edge register=0.
REQ-019 Reset asserted mid-APPLY SHALL discard all queued commands immediately.

Configuration
REQ-020 Macro VGA_CMD_FIFO_EN defined: 4-entry FIFO as specified; fifo_level ranges 0..4.
REQ-021 Macro VGA_CMD_FIFO_EN undefined: single holding register.
- Push while occupied is dropped and sets overflow, unless a pop occurs in the same cycle.
- fifo_level ranges 0..1.
- All other behaviour is unchanged.

Verification
REQ-022 Reset, then key 0x75 and one vblank rising edge -> half_h=25 one edge after the rise; half_w=20; busy back to 0.
REQ-023 22 x 0x72 from half_h=20 over several frames -> half_h saturates at 10 and never wraps; same check for 0x6B up to half_w=300.
REQ-024 Five keys queued with vblank=0 (FIFO_EN) -> fifo_level=4, overflow=1, and the first four commands are applied in order in one blanking interval.
REQ-025 0x2B, 0x2D, then 0x2C in one frame -> flash and invert both pulse to 1, then end at 0 with half_h=half_w=20.
REQ-026 vblank falls after 2 of 4 pops -> FSM in WAIT_VB with fifo_level=2, and the remaining commands are applied at the next rising edge.
REQ-027 key_valid coincident with a pop while full, plus reset during APPLY -> no overflow on the coincident push; after reset, all values are at their reset values.
